// File: rtl/wbscratch_pkg.sv
// ============================================================================
// Module : wbscratch_pkg
// Desc   : Register map, bit indices and decode kinds for wbscratchmem.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package wbscratch_pkg;

  localparam logic [1:0] ADDR_ID       = 2'd0;
  localparam logic [1:0] ADDR_CTRL     = 2'd1;
  localparam logic [1:0] ADDR_STATUS   = 2'd2;
  localparam logic [1:0] ADDR_DOORBELL = 2'd3;

  localparam int CTRL_INT_EN    = 0;
  localparam int STATUS_PEND    = 0;
  localparam int STATUS_ACC_LSB = 16;

  typedef enum logic [1:0] {
    DEC_REG = 2'd0,
    DEC_RAM = 2'd1,
    DEC_ERR = 2'd2
  } dec_e;

endpackage

`default_nettype wire

// File: rtl/wbscratch_bram.sv
// ============================================================================
// Module : wbscratch_bram
// Desc   : 1R1W synchronous block RAM, registered output, write-first bypass.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module wbscratch_bram #(
  parameter int AW = 10,
  parameter int DW = 32
) (
  input  logic          i_clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [DW-1:0] i_wdata,
  input  logic          i_re,
  input  logic [AW-1:0] i_raddr,
  output logic [DW-1:0] o_rdata
);

  logic [DW-1:0] r_mem [0:(2**AW)-1];
  logic [DW-1:0] r_q;

  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
    if (i_re) begin
      r_q <= (i_we && (i_waddr == i_raddr)) ? i_wdata : r_mem[i_raddr];
    end
  end

  assign o_rdata = r_q;

endmodule

`default_nettype wire

// File: rtl/wbscratchmem.sv
// ============================================================================
// Module : wbscratchmem
// Desc   : Wishbone B4 pipelined slave: CSR bank plus 2^AW x 32 scratch RAM.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module wbscratchmem
  import wbscratch_pkg::*;
#(
  parameter int          AW       = 10,
  parameter logic [31:0] RAM_BASE = 32'h0000_0400,
  parameter logic [31:0] ID_VALUE = 32'h4A32_4B01
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_wb_cyc,
  input  logic        i_wb_stb,
  input  logic        i_wb_we,
  input  logic [31:0] i_wb_addr,
  input  logic [31:0] i_wb_data,
  output logic        o_wb_ack,
  output logic        o_wb_stall,
  output logic        o_wb_err,
  output logic [31:0] o_wb_data,
  output logic        o_int
);

  logic        w_req;
  dec_e        w_dec;
  logic        w_reg_wr;
  logic        w_ram_wr;
  logic        w_ram_rd;
  logic [31:0] w_regrd;
  logic [31:0] w_ram_q;
  logic        w_issue;

  logic        r_int_en;
  logic        r_pend;
  logic [31:0] r_doorbell;
  logic [15:0] r_acccnt;
  logic        r_int;

  logic        r_v1;
  dec_e        r_kind1;
  logic [31:0] r_regq1;
  logic        r_v2;
  dec_e        r_kind2;
  logic [31:0] r_data2;
  logic        r_ack;
  logic        r_err;
  logic [31:0] r_dout;

  assign w_req = i_wb_cyc & i_wb_stb;

  always_comb begin
    w_dec = DEC_ERR;
    if (i_wb_addr[31:2] == 30'd0) begin
      w_dec = DEC_REG;
    end else if (i_wb_addr[31:AW] == RAM_BASE[31:AW]) begin
      w_dec = DEC_RAM;
    end
  end

  assign w_reg_wr = w_req & i_wb_we & (w_dec == DEC_REG);
  assign w_ram_wr = w_req & i_wb_we & (w_dec == DEC_RAM);
  assign w_ram_rd = w_req & ~i_wb_we & (w_dec == DEC_RAM);

  always_comb begin
    w_regrd = 32'd0;
    case (i_wb_addr[1:0])
      ADDR_ID:       w_regrd = ID_VALUE;
      ADDR_CTRL:     w_regrd[CTRL_INT_EN] = r_int_en;
      ADDR_STATUS: begin
        w_regrd[STATUS_PEND]                     = r_pend;
        w_regrd[STATUS_ACC_LSB+15:STATUS_ACC_LSB] = r_acccnt;
      end
      default:       w_regrd = r_doorbell;
    endcase
  end

  wbscratch_bram #(
    .AW (AW),
    .DW (32)
  ) u_bram (
    .i_clk   (i_clk),
    .i_we    (w_ram_wr),
    .i_waddr (i_wb_addr[AW-1:0]),
    .i_wdata (i_wb_data),
    .i_re    (w_ram_rd),
    .i_raddr (i_wb_addr[AW-1:0]),
    .o_rdata (w_ram_q)
  );

  // A dropped cycle kills the response of whatever sits in the last stage too.
  assign w_issue = r_v2 & i_wb_cyc;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_int_en   <= 1'b0;
      r_pend     <= 1'b0;
      r_doorbell <= 32'd0;
      r_acccnt   <= 16'd0;
      r_int      <= 1'b0;
      r_v1       <= 1'b0;
      r_kind1    <= DEC_ERR;
      r_regq1    <= 32'd0;
      r_v2       <= 1'b0;
      r_kind2    <= DEC_ERR;
      r_data2    <= 32'd0;
      r_ack      <= 1'b0;
      r_err      <= 1'b0;
      r_dout     <= 32'd0;
    end else begin
      if (w_reg_wr) begin
        case (i_wb_addr[1:0])
          ADDR_CTRL: r_int_en <= i_wb_data[CTRL_INT_EN];
          ADDR_STATUS: begin
            if (i_wb_data[STATUS_PEND]) begin
              r_pend <= 1'b0;
            end
          end
          ADDR_DOORBELL: begin
            r_doorbell <= i_wb_data;
            r_pend     <= 1'b1;
          end
          default: ;
        endcase
      end
      r_int <= r_pend & r_int_en;

      r_v1    <= w_req;
      r_kind1 <= w_dec;
      r_regq1 <= w_regrd;

      r_v2    <= r_v1 & i_wb_cyc;
      r_kind2 <= r_kind1;
      r_data2 <= (r_kind1 == DEC_RAM) ? w_ram_q :
                 (r_kind1 == DEC_REG) ? r_regq1 : 32'd0;

      r_ack  <= w_issue & (r_kind2 != DEC_ERR);
      r_err  <= w_issue & (r_kind2 == DEC_ERR);
      r_dout <= (w_issue && (r_kind2 != DEC_ERR)) ? r_data2 : 32'd0;
      if (w_issue && (r_kind2 != DEC_ERR)) begin
        r_acccnt <= r_acccnt + 16'd1;
      end
    end
  end

  assign o_wb_ack   = r_ack;
  assign o_wb_err   = r_err;
  assign o_wb_data  = r_dout;
  assign o_wb_stall = 1'b0;
  assign o_int      = r_int;

endmodule

`default_nettype wire

// File: tb/tb_wbscratchmem.sv
// ============================================================================
// Module : tb_wbscratchmem
// Desc   : Scoreboard bench for wbscratchmem against a behavioural model.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_wbscratchmem;

  localparam int          AW  = 10;
  localparam logic [31:0] RB  = 32'h0000_0400;
  localparam logic [31:0] IDV = 32'h4A32_4B01;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic        cyc   = 1'b0;
  logic        stb   = 1'b0;
  logic        we    = 1'b0;
  logic [31:0] addr  = 32'd0;
  logic [31:0] wdat  = 32'd0;
  logic        ack, stall, err, irq;
  logic [31:0] rdata;

  wbscratchmem #(.AW(AW), .RAM_BASE(RB), .ID_VALUE(IDV)) dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_wb_cyc   (cyc),
    .i_wb_stb   (stb),
    .i_wb_we    (we),
    .i_wb_addr  (addr),
    .i_wb_data  (wdat),
    .o_wb_ack   (ack),
    .o_wb_stall (stall),
    .o_wb_err   (err),
    .o_wb_data  (rdata),
    .o_int      (irq)
  );

  always #5 clk = ~clk;

  int edge_cnt = 0;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  typedef struct {
    bit          is_err;
    bit          chk;
    logic [31:0] data;
    int          due;
  } exp_t;

  exp_t sbq[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  bit   mon_en = 1'b0;

  // Reference model state
  logic [31:0] ram_m [int];
  bit          m_inten = 1'b0;
  bit          m_pend  = 1'b0;
  logic [31:0] m_db    = 32'd0;
  logic [15:0] m_acc   = 16'd0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: got %h required %h (edge %0d)", nm, act, expv, edge_cnt);
    end
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (mon_en && (ack || err)) begin
      if (sbq.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_resp: got ack=%0b err=%0b at edge %0d, required none",
                 ack, err, edge_cnt);
      end else begin
        e = sbq.pop_front();
        chk("resp_err", {31'd0, err}, {31'd0, e.is_err});
        chk("resp_ack", {31'd0, ack}, {31'd0, !e.is_err});
        chk("resp_cycle", edge_cnt, e.due);
        if (e.chk) chk("resp_data", rdata, e.data);
      end
    end
  end

  // Issues one request at the next edge; called and returns at a negedge.
  task automatic req(input bit w, input logic [31:0] a, input logic [31:0] d, input bit push = 1'b1);
    exp_t e;
    bit   is_reg, is_ram;
    if (a == 32'd2 && !w) begin
      stb = 1'b0;
      we  = 1'b0;
      repeat (2) @(negedge clk);
    end
    cyc = 1'b1; stb = 1'b1; we = w; addr = a; wdat = d;
    is_reg   = (a < 32'd4);
    is_ram   = (a >= RB) && (a < RB + 32'd1024);
    e.is_err = !(is_reg || is_ram);
    e.chk    = !w;
    e.data   = 32'd0;
    e.due    = edge_cnt + 3;
    if (is_ram) begin
      if (w) ram_m[int'(a)] = d;
      else if (ram_m.exists(int'(a))) e.data = ram_m[int'(a)];
      else e.chk = 1'b0;
    end else if (is_reg) begin
      case (a[1:0])
        2'd0: e.data = IDV;
        2'd1: begin
          e.data = {31'd0, m_inten};
          if (w) m_inten = d[0];
        end
        2'd2: begin
          e.data = {m_acc, 15'd0, m_pend};
          if (w && d[0]) m_pend = 1'b0;
        end
        default: begin
          e.data = m_db;
          if (w) begin m_db = d; m_pend = 1'b1; end
        end
      endcase
    end
    if (push) begin
      if (!e.is_err) m_acc = m_acc + 16'd1;
      sbq.push_back(e);
    end
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    stb = 1'b0;
    we  = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  initial begin : watchdog
    #1500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int          r, n;
    logic [31:0] a;
    repeat (3) @(negedge clk);
    chk("reset_ack",  {31'd0, ack}, 32'd0);
    chk("reset_err",  {31'd0, err}, 32'd0);
    chk("reset_int",  {31'd0, irq}, 32'd0);
    chk("reset_data", rdata, 32'd0);
    chk("stall_tied", {31'd0, stall}, 32'd0);
    rst_n  = 1'b1;
    cyc    = 1'b1;
    mon_en = 1'b1;
    @(negedge clk);

    // ID read, RAM write-then-read back to back
    req(0, 32'd0, 32'd0);
    idle(3);
    chk("int_idle", {31'd0, irq}, 32'd0);
    req(1, RB + 32'd5, 32'hDEADBEEF);
    req(0, RB + 32'd5, 32'd0);
    idle(3);

    // Interrupt path
    req(1, 32'd1, 32'd1);
    req(1, 32'd3, 32'h0000_00A5);
    chk("int_commit_edge", {31'd0, irq}, 32'd0);
    idle(1);
    chk("int_set", {31'd0, irq}, 32'd1);
    req(0, 32'd3, 32'd0);
    req(1, 32'd2, 32'd1);
    chk("int_before_clear", {31'd0, irq}, 32'd1);
    idle(1);
    chk("int_cleared", {31'd0, irq}, 32'd0);
    req(0, 32'd2, 32'd0);
    idle(3);

    // Out-of-map accesses
    req(0, 32'h0000_0010, 32'd0);
    req(0, RB + 32'd1024, 32'd0);
    req(1, 32'hFFFF_FFFF, 32'h1234_5678);
    req(0, 32'd2, 32'd0);
    idle(3);

    // Abort: only the first of three reads may complete
    req(0, RB + 32'd5, 32'd0, 1'b1);
    req(0, 32'd0, 32'd0, 1'b0);
    req(0, 32'd1, 32'd0, 1'b0);
    cyc = 1'b0;
    stb = 1'b0;
    repeat (4) @(negedge clk);
    cyc = 1'b1;
    req(0, 32'd2, 32'd0);
    idle(3);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      r = $urandom_range(0, 99);
      if (r < 25) a = $urandom_range(0, 3);
      else if (r < 75) a = RB + $urandom_range(0, 15);
      else if (r < 85) a = $urandom_range(4, 32'h3FF);
      else if (r < 95) a = RB + 32'd1024 + $urandom_range(0, 4096);
      else a = 32'hFFFF_FFFF - $urandom_range(0, 7);
      req(bit'($urandom_range(0, 1)), a, $urandom);
      if ($urandom_range(0, 9) == 0) idle(1);
    end
    idle(3);

    // Reset while reads are in flight
    req(0, RB + 32'd5, 32'd0, 1'b0);
    req(0, 32'd0, 32'd0, 1'b0);
    rst_n = 1'b0;
    stb   = 1'b0;
    repeat (2) @(negedge clk);
    rst_n   = 1'b1;
    m_inten = 1'b0;
    m_pend  = 1'b0;
    m_db    = 32'd0;
    m_acc   = 16'd0;
    idle(2);
    req(0, 32'd1, 32'd0);
    req(0, 32'd3, 32'd0);
    req(0, 32'd2, 32'd0);
    idle(3);

    // Counter wrap
    n = int'(16'hFFFF - m_acc);
    for (int i = 0; i < n; i++) req(0, 32'd0, 32'd0);
    req(0, 32'd2, 32'd0);
    req(0, 32'd2, 32'd0);
    idle(4);

    chk("scoreboard_empty", sbq.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
